calc_engine: RTL

CALC_ENGINE -- requirements
Module: calc_engine

---
 rtl/calc_pkg.sv | 31 +++
 rtl/calc_addsub.sv | 38 +++
 rtl/calc_engine.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared types for the calc engine: opcode and FSM state enums.
// Opcode encodings are the values software writes on cmd_op.
package calc_pkg;

  localparam logic [2:0] OP_ADD      = 3'd0;
  localparam logic [2:0] OP_SUB      = 3'd1;
  localparam logic [2:0] OP_ACC_ADD  = 3'd2;
  localparam logic [2:0] OP_ACC_SUB  = 3'd3;
  localparam logic [2:0] OP_HIST_ADD = 3'd4;
  localparam logic [2:0] OP_HIST_SUB = 3'd5;
  localparam logic [2:0] OP_CLEAR    = 3'd6;
  localparam logic [2:0] OP_NOP      = 3'd7;

  typedef enum logic [2:0] {
    C_ADD      = OP_ADD,
    C_SUB      = OP_SUB,
    C_ACC_ADD  = OP_ACC_ADD,
    C_ACC_SUB  = OP_ACC_SUB,
    C_HIST_ADD = OP_HIST_ADD,
    C_HIST_SUB = OP_HIST_SUB,
    C_CLEAR    = OP_CLEAR,
    C_NOP      = OP_NOP
  } calc_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } calc_state_e;

endpackage

// File: rtl/calc_addsub.sv
// Signed add/subtract with overflow flag; a_i +/- b_i -> sum_o, ovf_o.
// With CALC_SATURATE_EN defined, overflowing sums clamp to max/min.
module calc_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] raw;
  logic             sa;
  logic             sb;
  logic             sr;

  assign raw = sub_i ? (a_i - b_i) : (a_i + b_i);
  assign sa  = a_i[WIDTH-1];
  assign sb  = b_i[WIDTH-1];
  assign sr  = raw[WIDTH-1];

  // For a-b the effective operand is -b, so signs must differ.
  assign ovf_o = sub_i ? ((sa != sb) && (sr != sa))
                       : ((sa == sb) && (sr != sa));

`ifdef CALC_SATURATE_EN
  // On overflow the true result has the sign of a.
  logic [WIDTH-1:0] smax;
  logic [WIDTH-1:0] smin;
  assign smax = {1'b0, {(WIDTH-1){1'b1}}};
  assign smin = {1'b1, {(WIDTH-1){1'b0}}};
  assign sum_o = ovf_o ? (sa ? smin : smax) : raw;
`else
  assign sum_o = raw;
`endif

endmodule

// File: rtl/calc_engine.sv
// Command/response calc engine with accumulator and result history.
// Ports: cmd_* in (valid/ready), res_* out (valid/ready), acc_out.
// Optional CALC_SATURATE_EN: saturating arithmetic in calc_addsub.
module calc_engine
  import calc_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int HIST_DEPTH = 4,
  localparam int HW        = $clog2(HIST_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [HW-1:0]    cmd_hsel,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ovf,
  output logic [WIDTH-1:0] acc_out
);

  calc_state_e      state_q, state_d;
  calc_op_e         op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [HW-1:0]    hsel_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] hist_q [HIST_DEPTH];
  logic [WIDTH-1:0] res_q;
  logic             ovf_q;

  logic             accept;
  logic [WIDTH-1:0] hval;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             opsub;
  logic [WIDTH-1:0] sum;
  logic             sovf;
  logic [WIDTH-1:0] res_d;
  logic             ovf_d;
  logic             wr_en;
  logic             clr_en;

  assign cmd_ready = (state_q == S_IDLE);
  assign res_valid = (state_q == S_RESP);
  assign accept    = cmd_valid && cmd_ready;
  assign res_data  = res_q;
  assign res_ovf   = ovf_q;
  assign acc_out   = acc_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Indices past the last entry read as zero.
  always_comb begin
    hval = '0;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      if (HW'(i) == hsel_q) hval = hist_q[i];
    end
  end

  always_comb begin
    opa   = a_q;
    opb   = b_q;
    opsub = 1'b0;
    unique case (op_q)
      C_ADD:      ;
      C_SUB:      opsub = 1'b1;
      C_ACC_ADD:  begin opa = acc_q; opb = a_q; end
      C_ACC_SUB:  begin opa = acc_q; opb = a_q; opsub = 1'b1; end
      C_HIST_ADD: opb = hval;
      C_HIST_SUB: begin opb = hval; opsub = 1'b1; end
      C_CLEAR:    ;
      C_NOP:      ;
    endcase
  end

  calc_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a_i   (opa),
    .b_i   (opb),
    .sub_i (opsub),
    .sum_o (sum),
    .ovf_o (sovf)
  );

  always_comb begin
    res_d  = sum;
    ovf_d  = sovf;
    wr_en  = 1'b1;
    clr_en = 1'b0;
    if (op_q == C_CLEAR) begin
      res_d  = '0;
      ovf_d  = 1'b0;
      wr_en  = 1'b0;
      clr_en = 1'b1;
    end else if (op_q == C_NOP) begin
      res_d  = acc_q;
      ovf_d  = 1'b0;
      wr_en  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= C_NOP;
      a_q     <= '0;
      b_q     <= '0;
      hsel_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= calc_op_e'(cmd_op);
        a_q    <= cmd_a;
        b_q    <= cmd_b;
        hsel_q <= cmd_hsel;
      end
      if (state_q == S_EXEC) begin
        res_q <= res_d;
        ovf_q <= ovf_d;
        if (wr_en) begin
          acc_q     <= res_d;
          hist_q[0] <= res_d;
          for (int i = 1; i < HIST_DEPTH; i++) hist_q[i] <= hist_q[i-1];
        end else if (clr_en) begin
          acc_q <= '0;
          for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
        end
      end
    end
  end

endmodule
